cby_param_shadow: RTL and testbench

Parametrised Y-direction connection block for the eFPGA routing fabric. It passes CHAN_W bottom/top channel tracks straight through and drives NUM_IPIN grid input pins through MUX_SIZE-input routing muxes. Mux selects come from a scan configuration chain (ccff) with a double-buffered shadow/active register pair. A bit counter and an explicit commit step let the fabric be reprogrammed without glitching live mux outputs.

---
 rtl/cby_param_shadow_pkg.sv | 29 ++
 rtl/cby_route_mux.sv | 24 ++
 rtl/cby_param_shadow.sv | 88 ++++++++
 tb/tb_cby_param_shadow.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cby_param_shadow_pkg.sv
// Shared width and tap-index helpers for the Y-direction connection block.
// Keeps the derived widths consistent between the top level and the mux.
package cby_param_shadow_pkg;

  function automatic int clog2_w(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int sel_width(input int mux_size);
    return clog2_w(mux_size);
  endfunction

  function automatic int cfg_bits_of(input int num_ipin, input int mux_size);
    return num_ipin * sel_width(mux_size);
  endfunction

  // The counter has to reach CFG_BITS itself, hence the +1.
  function automatic int cnt_width(input int cfg_bits);
    return clog2_w(cfg_bits + 1);
  endfunction

  function automatic int tap_index(input int i, input int j, input int tap_step, input int chan_w);
    return (i + j * tap_step) % chan_w;
  endfunction

endpackage

// File: rtl/cby_route_mux.sv
// MUX_SIZE:1 routing mux for one grid input pin.
// An out-of-range select or a deasserted enable drives 0.
module cby_route_mux
  import cby_param_shadow_pkg::*;
#(
  parameter int MUX_SIZE = 10,
  parameter int SEL_W    = 4
) (
  input  logic [MUX_SIZE-1:0] data_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                enable,
  output logic                data_out
);

  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(MUX_SIZE);

  always_comb begin
    data_out = 1'b0;
    if (enable && ({1'b0, sel} < SEL_LIMIT)) begin
      data_out = data_in[sel];
    end
  end

endmodule

// File: rtl/cby_param_shadow.sv
// Y-direction connection block: pass-through tracks plus routing muxes whose
// selects come from a shadow/active double-buffered configuration chain.
module cby_param_shadow
  import cby_param_shadow_pkg::*;
#(
  parameter int CHAN_W   = 20,
  parameter int NUM_IPIN = 1,
  parameter int MUX_SIZE = 10,
  parameter int TAP_STEP = 2
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                config_enable,
  input  logic                ccff_head,
  input  logic                ccff_commit,
  input  logic [CHAN_W-1:0]   chany_bottom_in,
  input  logic [CHAN_W-1:0]   chany_top_in,
  output logic [CHAN_W-1:0]   chany_bottom_out,
  output logic [CHAN_W-1:0]   chany_top_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_loaded,
  output logic                cfg_valid,
  output logic                commit_err
);

  localparam int SEL_W    = sel_width(MUX_SIZE);
  localparam int CFG_BITS = cfg_bits_of(NUM_IPIN, MUX_SIZE);
  localparam int CNT_W    = cnt_width(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    cnt;
  logic                commit_ok;

  assign chany_bottom_out = chany_top_in;
  assign chany_top_out    = chany_bottom_in;

  assign ccff_tail  = shadow[CFG_BITS-1];
  assign cfg_loaded = (cnt == CNT_FULL);
  assign commit_ok  = ccff_commit & cfg_loaded & ~config_enable;

  // Live muxes only see active, so a shift in progress never reaches ipin_out.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow     <= '0;
      active     <= '0;
      cnt        <= '0;
      cfg_valid  <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      commit_err <= ccff_commit & ~commit_ok;
      if (config_enable) begin
        shadow <= (shadow << 1) | CFG_BITS'(ccff_head);
      end
      if (commit_ok) begin
        active    <= shadow;
        cnt       <= '0;
        cfg_valid <= 1'b1;
      end else if (config_enable && (cnt != CNT_FULL)) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_pin
    logic [MUX_SIZE-1:0] taps;

    for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_tap
      localparam int T = tap_index(i, j, TAP_STEP, CHAN_W);
      assign taps[2*j]   = chany_bottom_in[T];
      assign taps[2*j+1] = chany_top_in[T];
    end

    cby_route_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .data_in  (taps),
      .sel      (active[i*SEL_W +: SEL_W]),
      .enable   (cfg_valid),
      .data_out (ipin_out[i])
    );
  end

endmodule

// File: tb/tb_cby_param_shadow.sv
// Directed scoreboard bench for cby_param_shadow with CHAN_W=20, NUM_IPIN=2,
// MUX_SIZE=10, TAP_STEP=2 (SEL_W=4, CFG_BITS=8).
module tb_cby_param_shadow;

  logic        prog_clk = 1'b0;
  logic        pReset = 1'b0;
  logic        config_enable = 1'b0;
  logic        ccff_head = 1'b0;
  logic        ccff_commit = 1'b0;
  logic [19:0] chany_bottom_in = '0;
  logic [19:0] chany_top_in = '0;
  logic [19:0] chany_bottom_out;
  logic [19:0] chany_top_out;
  logic [1:0]  ipin_out;
  logic        ccff_tail;
  logic        cfg_loaded;
  logic        cfg_valid;
  logic        commit_err;

  int tests = 0;
  int fails = 0;

  string       tagQ[$];
  logic [31:0] expQ[$];

  logic [7:0] m_shadow = '0;
  logic [7:0] m_active = '0;
  int         m_cnt = 0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;

  cby_param_shadow #(
    .CHAN_W   (20),
    .NUM_IPIN (2),
    .MUX_SIZE (10),
    .TAP_STEP (2)
  ) dut (
    .prog_clk         (prog_clk),
    .pReset           (pReset),
    .config_enable    (config_enable),
    .ccff_head        (ccff_head),
    .ccff_commit      (ccff_commit),
    .chany_bottom_in  (chany_bottom_in),
    .chany_top_in     (chany_top_in),
    .chany_bottom_out (chany_bottom_out),
    .chany_top_out    (chany_top_out),
    .ipin_out         (ipin_out),
    .ccff_tail        (ccff_tail),
    .cfg_loaded       (cfg_loaded),
    .cfg_valid        (cfg_valid),
    .commit_err       (commit_err)
  );

  always #5 prog_clk = ~prog_clk;

  function automatic logic [1:0] modelIpin();
    logic [1:0] r;
    int sel, j, t;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      sel = int'(m_active[i*4 +: 4]);
      if (m_valid && sel < 10) begin
        j = sel / 2;
        t = (i + j * 2) % 20;
        r[i] = (sel % 2 == 1) ? chany_top_in[t] : chany_bottom_in[t];
      end
    end
    return r;
  endfunction

  task automatic pushExp(input string tag, input logic [31:0] value);
    tagQ.push_back(tag);
    expQ.push_back(value);
  endtask

  task automatic checkOutput(input logic [31:0] obs);
    string       tag;
    logic [31:0] expv;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $error("[TB] FAIL scoreboard_empty: observed %0h expected an entry", obs);
    end else begin
      tag  = tagQ.pop_front();
      expv = expQ.pop_front();
      assert (obs === expv) else begin
        fails++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
    end
  endtask

  task automatic checkExp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    pushExp(tag, expv);
    checkOutput(obs);
  endtask

  task automatic checkAll(input string tag);
    pushExp({tag, ".ipin"}, 32'(modelIpin()));
    pushExp({tag, ".tail"}, 32'(m_shadow[7]));
    pushExp({tag, ".loaded"}, 32'(m_cnt == 8));
    pushExp({tag, ".valid"}, 32'(m_valid));
    pushExp({tag, ".err"}, 32'(m_err));
    checkOutput(32'(ipin_out));
    checkOutput(32'(ccff_tail));
    checkOutput(32'(cfg_loaded));
    checkOutput(32'(cfg_valid));
    checkOutput(32'(commit_err));
  endtask

  // One clock edge with the given controls; the reference model steps on the same edge.
  task automatic applyStimulus(input logic en, input logic head, input logic commit, input logic rst);
    logic ok;
    config_enable = en;
    ccff_head     = head;
    ccff_commit   = commit;
    pReset        = rst;
    @(posedge prog_clk);
    if (rst) begin
      m_shadow = '0;
      m_active = '0;
      m_cnt    = 0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
    end else begin
      ok    = commit && (m_cnt == 8) && !en;
      m_err = commit && !ok;
      if (ok) begin
        m_active = m_shadow;
        m_cnt    = 0;
        m_valid  = 1'b1;
      end else if (en && m_cnt < 8) begin
        m_cnt++;
      end
      if (en) m_shadow = {m_shadow[6:0], head};
    end
    #1;
  endtask

  task automatic randomChannels();
    chany_bottom_in = 20'($urandom);
    chany_top_in    = 20'($urandom);
    #1;
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] p;

    // Reset with shift and commit also requested: reset must win.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("reset");
    checkExp("reset.ipin_zero", 32'(ipin_out), 32'h0);
    checkExp("reset.tail_zero", 32'(ccff_tail), 32'h0);
    chany_bottom_in = 20'hABCDE;
    #1;
    checkExp("pass.top_out", 32'(chany_top_out), 32'hABCDE);
    chany_top_in = 20'h12345;
    #1;
    checkExp("pass.bottom_out", 32'(chany_bottom_out), 32'h12345);

    // Load 0x35 MSB first and commit: sel_0=5 -> top[4], sel_1=3 -> top[3].
    v = 8'h35;
    for (int k = 7; k >= 0; k--) applyStimulus(1'b1, v[k], 1'b0, 1'b0);
    checkExp("load35.loaded", 32'(cfg_loaded), 32'h1);
    checkExp("load35.valid_before", 32'(cfg_valid), 32'h0);
    checkAll("load35");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkExp("commit35.valid", 32'(cfg_valid), 32'h1);
    checkExp("commit35.loaded_cleared", 32'(cfg_loaded), 32'h0);
    checkAll("commit35");
    for (int n = 0; n < 4; n++) begin
      randomChannels();
      checkExp("commit35.pin0", 32'(ipin_out[0]), 32'(chany_top_in[4]));
      checkExp("commit35.pin1", 32'(ipin_out[1]), 32'(chany_top_in[3]));
      checkAll("commit35.rand");
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkExp("recommit.err", 32'(commit_err), 32'h1);
    checkAll("recommit");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkExp("recommit.err_pulse_end", 32'(commit_err), 32'h0);

    // Load 0x2C with a premature commit and a commit during the 8th shift.
    v = 8'h2C;
    for (int k = 7; k >= 3; k--) applyStimulus(1'b1, v[k], 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkExp("early.err", 32'(commit_err), 32'h1);
    checkExp("early.valid_kept", 32'(cfg_valid), 32'h1);
    checkExp("early.pin0_kept", 32'(ipin_out[0]), 32'(chany_top_in[4]));
    checkAll("early");
    for (int k = 2; k >= 1; k--) applyStimulus(1'b1, v[k], 1'b0, 1'b0);
    checkExp("early.err_pulse_end", 32'(commit_err), 32'h0);
    applyStimulus(1'b1, v[0], 1'b1, 1'b0);
    checkExp("shiftcommit.err", 32'(commit_err), 32'h1);
    checkExp("shiftcommit.loaded", 32'(cfg_loaded), 32'h1);
    checkAll("shiftcommit");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkExp("commit2C.err", 32'(commit_err), 32'h0);
    checkAll("commit2C");
    for (int n = 0; n < 4; n++) begin
      randomChannels();
      checkExp("commit2C.pin0_oor", 32'(ipin_out[0]), 32'h0);
      checkExp("commit2C.pin1", 32'(ipin_out[1]), 32'(chany_bottom_in[3]));
    end

    // Partial reload must not disturb the live config.
    v = 8'h35;
    for (int k = 7; k >= 4; k--) applyStimulus(1'b1, v[k], 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      randomChannels();
      checkExp("partial.pin0_oor", 32'(ipin_out[0]), 32'h0);
      checkExp("partial.pin1", 32'(ipin_out[1]), 32'(chany_bottom_in[3]));
      checkAll("partial");
    end

    // 16-bit stream: tail replays the stream 8 edges later; counter saturates.
    p = 16'h5A5A;
    for (int s = 0; s < 16; s++) begin
      applyStimulus(1'b1, p[15-s], 1'b0, 1'b0);
      if (s >= 7) checkExp("stream.tail", 32'(ccff_tail), 32'(p[15-(s-7)]));
      checkAll("stream");
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("commit5A");
    for (int n = 0; n < 3; n++) begin
      randomChannels();
      checkExp("commit5A.pin0_oor", 32'(ipin_out[0]), 32'h0);
      checkExp("commit5A.pin1", 32'(ipin_out[1]), 32'(chany_top_in[5]));
    end

    // Reset mid-stream, with shift and commit requested on the same edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkExp("midreset.valid", 32'(cfg_valid), 32'h0);
    checkExp("midreset.loaded", 32'(cfg_loaded), 32'h0);
    checkExp("midreset.tail", 32'(ccff_tail), 32'h0);
    checkExp("midreset.ipin", 32'(ipin_out), 32'h0);
    checkAll("midreset");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkExp("postreset.commit_err", 32'(commit_err), 32'h1);
    checkAll("postreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
